// File: rtl/dcache_array_nway.sv
// -----------------------------------------------------------------------------
// dcache_array_nway
// N-way set-associative data-cache array: data RAM, tag RAM, valid/dirty bits
// and replacement state behind one VIPT lookup port. The set index comes from
// the virtual address at issue (stage 0); the physical tag arrives from the
// TLB one cycle later (stage 1), where hit detection and the response happen.
// A beat-serial refill engine installs lines, and an invalidate sweep clears
// valid/dirty for the whole cache one set per cycle.
//
// Optional feature macro: DCACHE_PLRU_EN
//   defined     -> tree pseudo-LRU, WAYS-1 bits per set, updated on hit/fill
//   not defined -> one global round-robin counter advanced on each fill
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           lookup handshake (stage 0)
//   req_index/req_word            set index, word within line
//   req_we/req_be/req_wdata       store flag, byte enables, store data
//   s1_ptag/s1_ptag_valid         TLB tag and hit, sampled in stage 1
//   rsp_valid/rsp_hit/rsp_way     lookup result (stage 1)
//   rsp_rdata                     load data, 0 on miss
//   rsp_victim_way/_dirty/_tag    replacement candidate for the looked-up set
//   fill_start/_index/_way/_tag   refill command
//   fill_valid/fill_ready/fill_data  refill beat handshake
//   fill_done                     pulse when the line is installed
//   inv_all/inv_done              invalidate-all request / completion pulse
//   busy                          high while in FILL or SWEEP
// -----------------------------------------------------------------------------
module dcache_array_nway #(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  parameter int PTAG_W     = 20,
  localparam int IDX_W     = $clog2(SETS),
  localparam int OFF_W     = $clog2(LINE_WORDS),
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_index,
  input  logic [OFF_W-1:0]  req_word,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [31:0]       req_wdata,
  input  logic [PTAG_W-1:0] s1_ptag,
  input  logic              s1_ptag_valid,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [WAY_W-1:0]  rsp_way,
  output logic [31:0]       rsp_rdata,
  output logic [WAY_W-1:0]  rsp_victim_way,
  output logic              rsp_victim_dirty,
  output logic [PTAG_W-1:0] rsp_victim_tag,
  input  logic              fill_start,
  input  logic [IDX_W-1:0]  fill_index,
  input  logic [WAY_W-1:0]  fill_way,
  input  logic [PTAG_W-1:0] fill_tag,
  input  logic              fill_valid,
  output logic              fill_ready,
  input  logic [31:0]       fill_data,
  output logic              fill_done,
  input  logic              inv_all,
  output logic              inv_done,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FILL, SWEEP} state_t;

  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
  localparam logic [IDX_W-1:0] LAST_SET  = IDX_W'(SETS - 1);

  state_t              state;
  logic [OFF_W-1:0]    beat_cnt;
  logic [IDX_W-1:0]    set_cnt;

  logic [SETS-1:0]     valid_q [WAYS];
  logic [SETS-1:0]     dirty_q [WAYS];
  logic [31:0]         data_mem [WAYS][SETS*LINE_WORDS];
  logic [PTAG_W-1:0]   tag_mem  [WAYS][SETS];

  logic [IDX_W-1:0]    fill_idx_q;
  logic [WAY_W-1:0]    fill_way_q;
  logic [PTAG_W-1:0]   fill_tag_q;

  logic                vld_p1;
  logic [IDX_W-1:0]    idx_p1;
  logic [OFF_W-1:0]    word_p1;
  logic                we_p1;
  logic [3:0]          be_p1;
  logic [31:0]         wdata_p1;
  logic [31:0]         data_rd_p1 [WAYS];
  logic [PTAG_W-1:0]   tag_rd_p1  [WAYS];

  logic                accept, fill_go, sweep_go, fill_beat, fill_last, st_we;
  logic [WAYS-1:0]     match;
  logic                hit;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_found;
  logic [WAY_W-1:0]    inv_way, pol_way, vic_way;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

`ifdef DCACHE_PLRU_EN
  localparam int TREE_W = WAYS - 1;
  logic [SETS*TREE_W-1:0] plru_q;

  // Heap-ordered tree, node n at bit n-1. A node bit of 1 points the victim
  // to the right subtree; touching a way makes every node on its path point away.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] t,
                                                   input logic [WAY_W-1:0]  w);
    logic [TREE_W-1:0] r;
    int node;
    r    = t;
    node = 1;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      r[node-1] = ~w[l];
      node      = 2 * node + (w[l] ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [TREE_W-1:0] t);
    logic [WAY_W-1:0] v;
    int node;
    v    = '0;
    node = 1;
    for (int l = WAY_W - 1; l >= 0; l--) begin
      v[l] = t[node-1];
      node = 2 * node + (t[node-1] ? 1 : 0);
    end
    return v;
  endfunction

  assign pol_way = plru_victim(plru_q[idx_p1*TREE_W +: TREE_W]);
`else
  logic [WAY_W-1:0] rr_q;
  assign pol_way = rr_q;
`endif

  // A store sitting in stage 1 writes at the end of this cycle, so no new
  // lookup is accepted alongside it.
  assign req_ready  = (state == IDLE) & ~inv_all & ~fill_start & ~(vld_p1 & we_p1);
  assign accept     = req_valid & req_ready;
  assign sweep_go   = (state == IDLE) & ~vld_p1 & inv_all;
  assign fill_go    = (state == IDLE) & ~vld_p1 & ~inv_all & fill_start;
  assign fill_beat  = (state == FILL) & fill_valid;
  assign fill_last  = fill_beat & (beat_cnt == LAST_BEAT);
  assign fill_ready = (state == FILL);
  assign busy       = (state != IDLE);

  // ---- stage 1: tag compare, way select, victim choice ----
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      match[w] = valid_q[w][idx_p1] & (tag_rd_p1[w] == s1_ptag) & s1_ptag_valid;
      if (match[w]) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][idx_p1]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign vic_way          = inv_found ? inv_way : pol_way;
  assign st_we            = vld_p1 & we_p1 & hit;
  assign rsp_valid        = vld_p1;
  assign rsp_hit          = vld_p1 & hit;
  assign rsp_way          = (vld_p1 & hit) ? hit_way : '0;
  assign rsp_rdata        = (vld_p1 & hit) ? data_rd_p1[hit_way] : '0;
  assign rsp_victim_way   = vld_p1 ? vic_way : '0;
  assign rsp_victim_dirty = vld_p1 & dirty_q[vic_way][idx_p1];
  assign rsp_victim_tag   = vld_p1 ? tag_rd_p1[vic_way] : '0;

  // ---- stage 0 -> stage 1: request capture and RAM reads; RAM writes ----
  always_ff @(posedge clk) begin
    if (accept) begin
      idx_p1   <= req_index;
      word_p1  <= req_word;
      we_p1    <= req_we;
      be_p1    <= req_be;
      wdata_p1 <= req_wdata;
      for (int w = 0; w < WAYS; w++) begin
        data_rd_p1[w] <= data_mem[w][{req_index, req_word}];
        tag_rd_p1[w]  <= tag_mem[w][req_index];
      end
    end
    if (fill_go) begin
      fill_idx_q <= fill_index;
      fill_way_q <= fill_way;
      fill_tag_q <= fill_tag;
    end
    if (fill_beat)
      data_mem[fill_way_q][{fill_idx_q, beat_cnt}] <= fill_data;
    else if (st_we)
      data_mem[hit_way][{idx_p1, word_p1}] <= byte_merge(data_rd_p1[hit_way], wdata_p1, be_p1);
    if (fill_last)
      tag_mem[fill_way_q][fill_idx_q] <= fill_tag_q;
  end

  // ---- control: FSM, valid/dirty, replacement state ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vld_p1    <= 1'b0;
      fill_done <= 1'b0;
      inv_done  <= 1'b0;
      beat_cnt  <= '0;
      set_cnt   <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
`ifdef DCACHE_PLRU_EN
      plru_q <= '0;
`else
      rr_q   <= '0;
`endif
    end else begin
      vld_p1    <= accept;
      fill_done <= 1'b0;
      inv_done  <= 1'b0;
      if (st_we)
        dirty_q[hit_way][idx_p1] <= 1'b1;
`ifdef DCACHE_PLRU_EN
      if (vld_p1 && hit)
        plru_q[idx_p1*TREE_W +: TREE_W] <= plru_touch(plru_q[idx_p1*TREE_W +: TREE_W], hit_way);
`endif
      case (state)
        IDLE: begin
          if (sweep_go) begin
            state   <= SWEEP;
            set_cnt <= '0;
          end else if (fill_go) begin
            state    <= FILL;
            beat_cnt <= '0;
            valid_q[fill_way][fill_index] <= 1'b0;
          end
        end
        FILL: begin
          if (fill_beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (fill_last) begin
              valid_q[fill_way_q][fill_idx_q] <= 1'b1;
              dirty_q[fill_way_q][fill_idx_q] <= 1'b0;
`ifdef DCACHE_PLRU_EN
              plru_q[fill_idx_q*TREE_W +: TREE_W] <=
                plru_touch(plru_q[fill_idx_q*TREE_W +: TREE_W], fill_way_q);
`else
              rr_q <= rr_q + 1'b1;
`endif
              fill_done <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        SWEEP: begin
          for (int w = 0; w < WAYS; w++) begin
            valid_q[w][set_cnt] <= 1'b0;
            dirty_q[w][set_cnt] <= 1'b0;
          end
          if (set_cnt == LAST_SET) begin
            inv_done <= 1'b1;
            state    <= IDLE;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_array_nway.sv
module tb_dcache_array_nway;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_index;
  logic [2:0]  req_word;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [19:0] s1_ptag;
  logic        s1_ptag_valid;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_victim_way;
  logic        rsp_victim_dirty;
  logic [19:0] rsp_victim_tag;
  logic        fill_start;
  logic [6:0]  fill_index;
  logic [1:0]  fill_way;
  logic [19:0] fill_tag;
  logic        fill_valid;
  logic        fill_ready;
  logic [31:0] fill_data;
  logic        fill_done;
  logic        inv_all;
  logic        inv_done;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n;

  dcache_array_nway #(.WAYS(4), .SETS(128), .LINE_WORDS(8), .PTAG_W(20)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_word(req_word),
    .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
    .s1_ptag(s1_ptag), .s1_ptag_valid(s1_ptag_valid),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .rsp_rdata(rsp_rdata),
    .rsp_victim_way(rsp_victim_way), .rsp_victim_dirty(rsp_victim_dirty),
    .rsp_victim_tag(rsp_victim_tag),
    .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
    .fill_tag(fill_tag), .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_data(fill_data), .fill_done(fill_done),
    .inv_all(inv_all), .inv_done(inv_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one lookup, then advance to the response cycle with the TLB tag
  // applied. Returns 1 ns after the falling edge of the response cycle.
  task automatic lookup(input logic [6:0] idx, input logic [2:0] word, input logic we,
                        input logic [3:0] be, input logic [31:0] wd,
                        input logic [19:0] ptag, input logic pv);
    @(negedge clk);
    req_valid = 1'b1; req_index = idx; req_word = word;
    req_we = we; req_be = be; req_wdata = wd;
    #1 chk("req_ready_issue", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    s1_ptag = ptag; s1_ptag_valid = pv;
    #1;
  endtask

  task automatic do_fill(input logic [6:0] idx, input logic [1:0] way, input logic [19:0] tag,
                         input logic [31:0] base, input bit stall);
    @(negedge clk);
    fill_start = 1'b1; fill_index = idx; fill_way = way; fill_tag = tag;
    @(negedge clk);
    fill_start = 1'b0;
    #1 chk("fill_busy", 32'(busy), 32'd1);
    for (int b = 0; b < 8; b++) begin
      if (stall && b == 2) begin
        fill_valid = 1'b0;
        @(negedge clk);
      end
      fill_valid = 1'b1; fill_data = base + 32'(b);
      #1 chk("fill_ready", 32'(fill_ready), 32'd1);
      @(negedge clk);
    end
    fill_valid = 1'b0;
    #1;
    chk("fill_done", 32'(fill_done), 32'd1);
    chk("fill_busy_end", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_index = '0; req_word = '0; req_we = 1'b0;
    req_be = '0; req_wdata = '0; s1_ptag = '0; s1_ptag_valid = 1'b0;
    fill_start = 1'b0; fill_index = '0; fill_way = '0; fill_tag = '0;
    fill_valid = 1'b0; fill_data = '0; inv_all = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_victim_way", 32'(rsp_victim_way), 32'd0);
    chk("rst_victim_dirty", 32'(rsp_victim_dirty), 32'd0);
    chk("rst_victim_tag", 32'(rsp_victim_tag), 32'd0);
    chk("rst_fill_ready", 32'(fill_ready), 32'd0);
    chk("rst_fill_done", 32'(fill_done), 32'd0);
    chk("rst_inv_done", 32'(inv_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Fill set 5 way 2 with words 0..7 (one stall beat); round robin -> 1.
    do_fill(7'd5, 2'd2, 20'h12345, 32'd0, 1'b1);
    // Lookup issued in the fill_done cycle must see the new line.
    req_valid = 1'b1; req_index = 7'd5; req_word = 3'd3; req_we = 1'b0;
    #1 chk("req_ready_at_fill_done", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; s1_ptag = 20'h12345; s1_ptag_valid = 1'b1;
    #1;
    chk("fill_done_pulse", 32'(fill_done), 32'd0);
    chk("ld1_valid", 32'(rsp_valid), 32'd1);
    chk("ld1_hit", 32'(rsp_hit), 32'd1);
    chk("ld1_way", 32'(rsp_way), 32'd2);
    chk("ld1_rdata", rsp_rdata, 32'd3);
    chk("ld1_victim_way", 32'(rsp_victim_way), 32'd0);
    lookup(7'd5, 3'd2, 1'b0, 4'h0, 32'd0, 20'h12345, 1'b1);
    chk("ld_stalled_beat", rsp_rdata, 32'd2);

    // Store hit with partial byte enables: one-cycle bubble, then merged data.
    lookup(7'd5, 3'd3, 1'b1, 4'b0011, 32'hAABBCCDD, 20'h12345, 1'b1);
    chk("st_hit", 32'(rsp_hit), 32'd1);
    chk("st_bubble", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1 chk("st_bubble_end", 32'(req_ready), 32'd1);
    lookup(7'd5, 3'd3, 1'b0, 4'h0, 32'd0, 20'h12345, 1'b1);
    chk("ld_merged", rsp_rdata, 32'h0000CCDD);
    chk("ld_merged_victim_dirty", 32'(rsp_victim_dirty), 32'd0);

    // TLB miss and wrong tag both miss; state unchanged afterwards.
    lookup(7'd5, 3'd3, 1'b0, 4'h0, 32'd0, 20'h12345, 1'b0);
    chk("tlbmiss_valid", 32'(rsp_valid), 32'd1);
    chk("tlbmiss_hit", 32'(rsp_hit), 32'd0);
    chk("tlbmiss_rdata", rsp_rdata, 32'd0);
    lookup(7'd5, 3'd3, 1'b0, 4'h0, 32'd0, 20'h12346, 1'b1);
    chk("wrongtag_hit", 32'(rsp_hit), 32'd0);
    lookup(7'd5, 3'd3, 1'b0, 4'h0, 32'd0, 20'h12345, 1'b1);
    chk("after_miss_rdata", rsp_rdata, 32'h0000CCDD);

    // Fill remaining ways of set 5 (rr 1->0) and all ways of set 9 (rr stays 0).
    do_fill(7'd5, 2'd0, 20'hA0000, 32'h100, 1'b0);
    do_fill(7'd5, 2'd1, 20'hA0001, 32'h200, 1'b0);
    do_fill(7'd5, 2'd3, 20'hA0003, 32'h300, 1'b0);
    for (int w = 0; w < 4; w++)
      do_fill(7'd9, 2'(w), 20'hB0000 + 20'(w), 32'h900 + 32'(16 * w), 1'b0);
    lookup(7'd9, 3'd1, 1'b0, 4'h0, 32'd0, 20'hB0000, 1'b1);
    chk("s9_w0_way", 32'(rsp_way), 32'd0);
    chk("s9_w0_rdata", rsp_rdata, 32'h901);
    lookup(7'd9, 3'd1, 1'b0, 4'h0, 32'd0, 20'hB0001, 1'b1);
    chk("s9_w1_way", 32'(rsp_way), 32'd1);
    chk("s9_w1_rdata", rsp_rdata, 32'h911);
    lookup(7'd9, 3'd1, 1'b0, 4'h0, 32'd0, 20'hB0003, 1'b1);
    chk("s9_w3_way", 32'(rsp_way), 32'd3);
    chk("s9_w3_rdata", rsp_rdata, 32'h931);
    chk("s9_victim_way_rr", 32'(rsp_victim_way), 32'd0);
    chk("s9_victim_tag", 32'(rsp_victim_tag), 32'hB0000);
    chk("s9_victim_dirty", 32'(rsp_victim_dirty), 32'd0);

    // Set 20: two ways with the same tag (lowest wins); rr -> 2.
    do_fill(7'd20, 2'd0, 20'hC0000, 32'hC00, 1'b0);
    do_fill(7'd20, 2'd1, 20'hC0000, 32'hD00, 1'b0);
    lookup(7'd20, 3'd4, 1'b0, 4'h0, 32'd0, 20'hC0000, 1'b1);
    chk("dual_match_way", 32'(rsp_way), 32'd0);
    chk("dual_match_rdata", rsp_rdata, 32'hC04);
    chk("s20_victim_invalid", 32'(rsp_victim_way), 32'd2);
    lookup(7'd5, 3'd0, 1'b0, 4'h0, 32'd0, 20'hA0000, 1'b1);
    chk("s5_w0_rdata", rsp_rdata, 32'h100);
    chk("s5_victim_way", 32'(rsp_victim_way), 32'd2);
    chk("s5_victim_dirty", 32'(rsp_victim_dirty), 32'd1);
    chk("s5_victim_tag", 32'(rsp_victim_tag), 32'h12345);

    // Back-to-back loads: one response per cycle.
    @(negedge clk);
    req_valid = 1'b1; req_index = 7'd9; req_word = 3'd5; req_we = 1'b0;
    @(negedge clk);
    req_index = 7'd5; req_word = 3'd3; s1_ptag = 20'hB0001; s1_ptag_valid = 1'b1;
    #1;
    chk("b2b_a_rdata", rsp_rdata, 32'h915);
    chk("b2b_a_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; s1_ptag = 20'h12345;
    #1;
    chk("b2b_b_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_b_way", 32'(rsp_way), 32'd2);
    chk("b2b_b_rdata", rsp_rdata, 32'h0000CCDD);

    // inv_all together with fill_start: sweep wins.
    @(negedge clk);
    inv_all = 1'b1; fill_start = 1'b1; fill_index = 7'd5; fill_way = 2'd0;
    #1 chk("inv_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    inv_all = 1'b0; fill_start = 1'b0;
    #1 chk("sweep_no_fill", 32'(fill_ready), 32'd0);
    n = 0;
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("sweep_cycles", 32'(n), 32'd128);
    chk("inv_done", 32'(inv_done), 32'd1);
    @(negedge clk);
    #1 chk("inv_done_pulse", 32'(inv_done), 32'd0);
    lookup(7'd5, 3'd3, 1'b0, 4'h0, 32'd0, 20'h12345, 1'b1);
    chk("post_inv_s5_hit", 32'(rsp_hit), 32'd0);
    chk("post_inv_s5_victim", 32'(rsp_victim_way), 32'd0);
    chk("post_inv_s5_dirty", 32'(rsp_victim_dirty), 32'd0);
    lookup(7'd20, 3'd4, 1'b0, 4'h0, 32'd0, 20'hC0000, 1'b1);
    chk("post_inv_s20_hit", 32'(rsp_hit), 32'd0);

    // Reset on fill beat 4.
    @(negedge clk);
    fill_start = 1'b1; fill_index = 7'd7; fill_way = 2'd1; fill_tag = 20'h77777;
    @(negedge clk);
    fill_start = 1'b0;
    for (int b = 0; b < 4; b++) begin
      fill_valid = 1'b1; fill_data = 32'h700 + 32'(b);
      @(negedge clk);
    end
    fill_valid = 1'b1; fill_data = 32'h704; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; fill_valid = 1'b0;
    #1;
    chk("rst_fill_fill_ready", 32'(fill_ready), 32'd0);
    chk("rst_fill_busy", 32'(busy), 32'd0);
    chk("rst_fill_req_ready", 32'(req_ready), 32'd1);
    lookup(7'd7, 3'd0, 1'b0, 4'h0, 32'd0, 20'h77777, 1'b1);
    chk("rst_fill_line_miss", 32'(rsp_hit), 32'd0);

    // A full refill after the interrupted one lands every word correctly.
    do_fill(7'd7, 2'd1, 20'h77777, 32'h700, 1'b0);
    lookup(7'd7, 3'd7, 1'b0, 4'h0, 32'd0, 20'h77777, 1'b1);
    chk("refill_hit", 32'(rsp_hit), 32'd1);
    chk("refill_way", 32'(rsp_way), 32'd1);
    chk("refill_rdata", rsp_rdata, 32'h707);
    chk("refill_victim", 32'(rsp_victim_way), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
